// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit: multi-cycle diff = a - b - b_in, SLICE_W bits per clock, LSB slice first.
// Optional macro SUB_OVF_EN adds the registered two's-complement overflow output ovf.
module serial_subtractor_16bit #(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             brw_q, brw_d;
   logic             b_out_q, b_out_d;
   logic             done_q, done_d;
   logic [SLICE_W:0] slice_res;
`ifdef SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // One slice of unsigned subtraction; the extra MSB is the borrow out of the slice.
   function automatic logic [SLICE_W:0] sub_slice(input logic [SLICE_W-1:0] x,
                                                  input logic [SLICE_W-1:0] y,
                                                  input logic               bi);
      return {1'b0, x} - {1'b0, y} - {{SLICE_W{1'b0}}, bi};
   endfunction

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      work_d    = work_q;
      diff_d    = diff_q;
      idx_d     = idx_q;
      brw_d     = brw_q;
      b_out_d   = b_out_q;
      done_d    = 1'b0;
`ifdef SUB_OVF_EN
      ovf_d     = ovf_q;
`endif
      slice_res = sub_slice(a_q[idx_q*SLICE_W +: SLICE_W], b_q[idx_q*SLICE_W +: SLICE_W], brw_q);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = b_in;
               idx_d   = '0;
               work_d  = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            work_d[idx_q*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
            brw_d = slice_res[SLICE_W];
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            // Results land together with the done pulse in the following cycle.
            diff_d  = work_q;
            b_out_d = brw_q;
            done_d  = 1'b1;
`ifdef SUB_OVF_EN
            ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (work_q[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         brw_q   <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         brw_q   <= brw_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         b_out_q <= b_out_d;
`ifdef SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Operand and working registers are always rewritten on acceptance, so they need no reset.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      work_q <= work_d;
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q == S_RUN);
   assign done  = done_q;
   assign diff  = diff_q;
   assign b_out = b_out_q;
`ifdef SUB_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Bench for serial_subtractor_16bit: three instances (SLICE_W 1/4/16) share one stimulus
// and are compared every cycle against a cycle-count plus 17-bit-arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtractor_16bit;
   logic        clk = 1'b0;
   logic        rst_n, start, b_in;
   logic [15:0] a, b;
   logic        rdy [3];
   logic        bsy [3];
   logic        dn  [3];
   logic        bo  [3];
   logic [15:0] df  [3];
`ifdef SUB_OVF_EN
   logic        ov  [3];
`endif

   always #5 clk = ~clk;

   serial_subtractor_16bit #(.WIDTH(16), .SLICE_W(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
      .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .diff(df[0]), .b_out(bo[0])
`ifdef SUB_OVF_EN
      , .ovf(ov[0])
`endif
   );
   serial_subtractor_16bit #(.WIDTH(16), .SLICE_W(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
      .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .diff(df[1]), .b_out(bo[1])
`ifdef SUB_OVF_EN
      , .ovf(ov[1])
`endif
   );
   serial_subtractor_16bit #(.WIDTH(16), .SLICE_W(16)) u_s16 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
      .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .diff(df[2]), .b_out(bo[2])
`ifdef SUB_OVF_EN
      , .ovf(ov[2])
`endif
   );

   // Reference model: cycles left before IDLE, pending and visible results.
   int          nsl [3] = '{16, 4, 1};
   int          rem [3];
   logic [16:0] pend [3];
   logic [16:0] exp_res [3];
   logic        pend_ovf [3];
   logic        exp_ovf [3];
   logic        exp_done [3];
   int          acc_cyc [3];
   int          done_cyc [3];
   int          dut_ndone [3];
   int          cyc;
   int          checks;
   int          failures;

   task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s inst=%0d cycle=%0d got=%0h expected=%0h", name, j, cyc, act, expv);
      end
   endtask

   // Advance one clock edge, update the model with the inputs seen at that edge, compare all outputs.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int j = 0; j < 3; j++) begin
         exp_done[j] = 1'b0;
         if (!rst_n) begin
            rem[j]     = 0;
            exp_res[j] = '0;
            exp_ovf[j] = 1'b0;
         end else if (rem[j] > 0) begin
            rem[j]--;
            if (rem[j] == 0) begin
               exp_done[j] = 1'b1;
               exp_res[j]  = pend[j];
               exp_ovf[j]  = pend_ovf[j];
               done_cyc[j] = cyc;
            end
         end else if (start) begin
            rem[j]      = nsl[j] + 1;
            pend[j]     = {1'b0, a} - {1'b0, b} - {16'b0, b_in};
            pend_ovf[j] = (a[15] ^ b[15]) & (pend[j][15] ^ a[15]);
            acc_cyc[j]  = cyc;
         end
         if (dn[j]) dut_ndone[j]++;
         chk("ready", j, 32'(rdy[j]), 32'(rem[j] == 0));
         chk("busy", j, 32'(bsy[j]), 32'(rem[j] >= 2));
         chk("done", j, 32'(dn[j]), 32'(exp_done[j]));
         chk("result", j, 32'({bo[j], df[j]}), 32'(exp_res[j]));
`ifdef SUB_OVF_EN
         chk("ovf", j, 32'(ov[j]), 32'(exp_ovf[j]));
`endif
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(rem[0] == 0 && rem[1] == 0 && rem[2] == 0) && t < 40) begin
         step();
         t++;
      end
      if (t >= 40) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout cycle=%0d got=busy expected=idle", cyc);
      end
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      a     = av;
      b     = bv;
      b_in  = bi;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle();
   endtask

   task automatic chk_all(input string name, input logic [16:0] expv);
      for (int j = 0; j < 3; j++) begin
         chk(name, j, 32'({bo[j], df[j]}), 32'(expv));
         chk({name, "_model"}, j, 32'(exp_res[j]), 32'(expv));
      end
   endtask

   function automatic logic [15:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      int d1;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      for (int j = 0; j < 3; j++) begin
         rem[j] = 0; exp_res[j] = '0; exp_ovf[j] = 1'b0; pend[j] = '0; pend_ovf[j] = 1'b0;
         exp_done[j] = 1'b0; acc_cyc[j] = 0; done_cyc[j] = 0; dut_ndone[j] = 0;
      end
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      step();
      step();
      for (int j = 0; j < 3; j++) begin
         chk("rst_ready", j, 32'(rdy[j]), 32'd1);
         chk("rst_done", j, 32'(dn[j]), 32'd0);
         chk("rst_result", j, 32'({bo[j], df[j]}), 32'd0);
      end
      rst_n = 1'b1;
      step();

      // Basic operation and latency of the default slicing.
      run_op(16'h1234, 16'h0034, 1'b0);
      chk_all("t1", 17'h01200);
      chk("t1_latency", 1, 32'(done_cyc[1] - acc_cyc[1]), 32'd5);
      chk("t1_latency_s1", 0, 32'(done_cyc[0] - acc_cyc[0]), 32'd17);

      // Wrap-around and borrow out.
      run_op(16'h0000, 16'h0001, 1'b0);
      chk_all("t2a", 17'h1FFFF);
      run_op(16'h0000, 16'hFFFF, 1'b1);
      chk_all("t2b", 17'h10000);

      // Signed overflow cases.
      run_op(16'h8000, 16'h0000, 1'b1);
      chk_all("t3a", 17'h07FFF);
`ifdef SUB_OVF_EN
      for (int j = 0; j < 3; j++) chk("t3a_ovf", j, 32'(ov[j]), 32'd1);
`endif
      run_op(16'h0000, 16'h7FFF, 1'b1);
      chk_all("t3b", 17'h18000);
`ifdef SUB_OVF_EN
      for (int j = 0; j < 3; j++) chk("t3b_ovf", j, 32'(ov[j]), 32'd0);
`endif

      // A second start while running must be ignored.
      d1    = dut_ndone[1];
      a     = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
      step();
      a     = 16'hFFFF; b = 16'h0000; b_in = 1'b1;
      step();
      start = 1'b0;
      wait_idle();
      chk("t4_result", 1, 32'({bo[1], df[1]}), 32'h01200);
      chk("t4_done_count", 1, 32'(dut_ndone[1] - d1), 32'd1);

      // Reset in the middle of an operation discards it.
      d0    = dut_ndone[0];
      d1    = dut_ndone[1];
      a     = 16'hABCD; b = 16'h0123; b_in = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         chk("t5_ready", j, 32'(rdy[j]), 32'd1);
         chk("t5_done", j, 32'(dn[j]), 32'd0);
         chk("t5_result", j, 32'({bo[j], df[j]}), 32'd0);
      end
      for (int t = 0; t < 20; t++) step();
      chk("t5_no_done_s1", 0, 32'(dut_ndone[0] - d0), 32'd0);
      chk("t5_no_done_s4", 1, 32'(dut_ndone[1] - d1), 32'd0);

      // Randomized back-to-back traffic with operands changing every cycle.
      for (int t = 0; t < 40000; t++) begin
         start = ($urandom_range(0, 7) != 0);
         a     = rnd_op();
         b     = rnd_op();
         b_in  = 1'($urandom_range(0, 1));
         step();
      end
      start = 1'b0;
      wait_idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
